// File: rtl/uart_bus_initiator.sv
// Register-port initiator for the memory-mapped UART: polls control, pushes Tx bytes,
// pulls Rx bytes, and bridges both directions to valid/ready streams.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// S_INIT    | issue the initial control write (irq enable only)
// S_IDLE    | count down the poll interval; accept a Tx byte into the hold reg
// S_POLL    | issue a read of the control register
// S_DECIDE  | pick Rx read, Tx write or back to idle from the shadowed flags
// S_RD_RX   | issue a read of the Rx buffer
// S_CLR     | issue the control write that clears RX_AVAL; publish rx_data
// S_WR_TX   | issue a write of the held byte to the Tx buffer
// S_WR      | write cycle on the bus (cs=0, wr=0)
// S_RD      | read start cycle (cs=0, rd_strobe=1)
// S_RD_WAIT | wait for rd_busy 1 then 0, or time out
// S_GAP     | cs held high between accesses, then continue at ret
module uart_bus_initiator #(
  parameter int CTL_RX_AVAL_BIT  = 0,
  parameter int CTL_TX_BUSY_BIT  = 1,
  parameter int CTL_IRQ_ENAB_BIT = 2,
  parameter int POLL_INTERVAL    = 16,
  parameter int GAP_CYCLES       = 3,
  parameter int TIMEOUT          = 64
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       irq_en,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       cs,
  output logic       wr,
  output logic       rd_strobe,
  input  logic       rd_busy,
  output logic [2:0] addr,
  output logic [7:0] bus_wdata,
  input  logic [7:0] bus_rdata,
  input  logic       irq,
  output logic       timeout_err
);

  localparam int PW = $clog2(POLL_INTERVAL + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [PW-1:0] POLL_LOAD = PW'(POLL_INTERVAL - 1);
  localparam logic [GW-1:0] GAP_LOAD  = GW'(GAP_CYCLES - 1);
  localparam logic [TW-1:0] TO_LOAD   = TW'(TIMEOUT - 1);

  typedef enum logic [3:0] {
    S_INIT, S_IDLE, S_POLL, S_DECIDE, S_RD_RX, S_CLR, S_WR_TX,
    S_WR, S_RD, S_RD_WAIT, S_GAP
  } state_t;

  state_t        state, ret;
  logic          shadow_rx_aval, shadow_tx_busy;
  logic [7:0]    hold;
  logic          hold_full, seen_busy, irq_pend;
  logic [PW-1:0] poll_cnt;
  logic [GW-1:0] gap_cnt;
  logic [TW-1:0] to_cnt;
  logic [7:0]    ctl_word;

  // Control writes carry only the irq enable; RX_AVAL and TX_BUSY are written as 0.
  always_comb begin
    ctl_word = '0;
    ctl_word[CTL_IRQ_ENAB_BIT] = irq_en;
  end

  assign tx_ready = (state == S_IDLE) && !hold_full;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state          <= S_INIT;
      ret            <= S_IDLE;
      cs             <= 1'b1;
      wr             <= 1'b1;
      rd_strobe      <= 1'b0;
      addr           <= '0;
      bus_wdata      <= '0;
      rx_data        <= '0;
      rx_valid       <= 1'b0;
      timeout_err    <= 1'b0;
      shadow_rx_aval <= 1'b0;
      shadow_tx_busy <= 1'b0;
      hold           <= '0;
      hold_full      <= 1'b0;
      seen_busy      <= 1'b0;
      irq_pend       <= 1'b0;
      poll_cnt       <= POLL_LOAD;
      gap_cnt        <= GAP_LOAD;
      to_cnt         <= TO_LOAD;
    end else begin
      if (irq) irq_pend <= 1'b1;
      if (rx_valid && rx_ready) rx_valid <= 1'b0;
      case (state)
        S_INIT: begin
          cs <= 1'b0; wr <= 1'b0; addr <= 3'd0; bus_wdata <= ctl_word;
          ret <= S_IDLE; state <= S_WR;
        end
        S_IDLE: begin
          if (tx_valid && !hold_full) begin
            hold      <= tx_data;
            hold_full <= 1'b1;
          end
          if (poll_cnt == '0 || irq || irq_pend) begin
            irq_pend <= 1'b0;
            state    <= S_POLL;
          end else begin
            poll_cnt <= poll_cnt - PW'(1);
          end
        end
        S_POLL: begin
          cs <= 1'b0; rd_strobe <= 1'b1; addr <= 3'd0; state <= S_RD;
        end
        S_DECIDE: begin
          if (shadow_rx_aval && !rx_valid) begin
            state <= S_RD_RX;
          end else if (hold_full && !shadow_tx_busy) begin
            state <= S_WR_TX;
          end else begin
            poll_cnt <= POLL_LOAD;
            state    <= S_IDLE;
          end
        end
        S_RD_RX: begin
          cs <= 1'b0; rd_strobe <= 1'b1; addr <= 3'd1; state <= S_RD;
        end
        S_CLR: begin
          cs <= 1'b0; wr <= 1'b0; addr <= 3'd0; bus_wdata <= ctl_word;
          rx_valid <= 1'b1;
          ret <= S_IDLE; state <= S_WR;
        end
        S_WR_TX: begin
          cs <= 1'b0; wr <= 1'b0; addr <= 3'd2; bus_wdata <= hold;
          hold_full <= 1'b0;
          ret <= S_IDLE; state <= S_WR;
        end
        S_WR: begin
          cs <= 1'b1; wr <= 1'b1; gap_cnt <= GAP_LOAD; state <= S_GAP;
        end
        S_RD: begin
          rd_strobe <= 1'b0; seen_busy <= 1'b0; to_cnt <= TO_LOAD;
          state <= S_RD_WAIT;
        end
        S_RD_WAIT: begin
          if (rd_busy) seen_busy <= 1'b1;
          if (seen_busy && !rd_busy) begin
            if (addr == 3'd0) begin
              shadow_rx_aval <= bus_rdata[CTL_RX_AVAL_BIT];
              shadow_tx_busy <= bus_rdata[CTL_TX_BUSY_BIT];
              ret <= S_DECIDE;
            end else begin
              rx_data <= bus_rdata;
              ret <= S_CLR;
            end
            cs <= 1'b1; gap_cnt <= GAP_LOAD; state <= S_GAP;
          end else if (to_cnt == '0) begin
            // Abandon the read; any Rx byte stays in the component for a later poll.
            timeout_err <= 1'b1;
            cs <= 1'b1; poll_cnt <= POLL_LOAD; state <= S_IDLE;
          end else begin
            to_cnt <= to_cnt - TW'(1);
          end
        end
        S_GAP: begin
          if (gap_cnt == '0) begin
            poll_cnt <= POLL_LOAD;
            state    <= ret;
          end else begin
            gap_cnt <= gap_cnt - GW'(1);
          end
        end
        default: state <= S_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_bus_initiator.sv
// Directed bench for uart_bus_initiator: a small UART register-port responder model
// logs every bus access, and each test task checks the logged sequence and stream outputs.
module tb_uart_bus_initiator;

  localparam int TIMEOUT = 64;
  localparam int GAP     = 3;

  logic       clock = 0;
  logic       reset = 0;
  logic       irq_en = 1;
  logic [7:0] tx_data = 0;
  logic       tx_valid = 0;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready = 1;
  logic       cs, wr, rd_strobe;
  logic       rd_busy = 0;
  logic [2:0] addr;
  logic [7:0] bus_wdata;
  logic [7:0] bus_rdata = 0;
  logic       irq = 0;
  logic       timeout_err;

  int vectors = 0;
  int miscompares = 0;

  typedef struct packed {
    logic       is_wr;
    logic [2:0] a;
    logic [7:0] d;
  } acc_t;

  acc_t acc_q[$];
  logic [7:0] ctl_reg = 0;
  logic [7:0] rx_reg = 0;
  logic       no_busy = 0;

  uart_bus_initiator dut (
    .clock(clock), .reset(reset), .irq_en(irq_en),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .cs(cs), .wr(wr), .rd_strobe(rd_strobe), .rd_busy(rd_busy),
    .addr(addr), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
    .irq(irq), .timeout_err(timeout_err)
  );

  always #5 clock = ~clock;

  // Responder model: busy rises the cycle after rd_strobe and falls one cycle later.
  always @(posedge clock) begin
    logic       busy_n;
    logic       load;
    logic [7:0] rdata_n;
    load = 0;
    rdata_n = bus_rdata;
    if (reset) begin
      if (!cs && !wr) begin
        acc_q.push_back('{is_wr: 1'b1, a: addr, d: bus_wdata});
        if (addr == 3'd0) ctl_reg = bus_wdata;
      end
      if (rd_strobe) begin
        acc_q.push_back('{is_wr: 1'b0, a: addr, d: 8'h00});
        rdata_n = (addr == 3'd0) ? ctl_reg : rx_reg;
        load = 1;
      end
    end
    busy_n = rd_busy ? 1'b0 : (rd_strobe && !no_busy);
    #1;
    rd_busy = busy_n;
    if (load) bus_rdata = rdata_n;
  end

  function automatic acc_t mk(input logic w, input logic [2:0] a, input logic [7:0] d);
    mk = '{is_wr: w, a: a, d: d};
  endfunction

  task automatic next_acc(output acc_t e, output bit ok);
    int n;
    n = 0;
    while (acc_q.size() == 0 && n < 400) begin
      @(negedge clock);
      n++;
    end
    ok = (acc_q.size() != 0);
    e = '0;
    if (ok) e = acc_q.pop_front();
  endtask

  task automatic next_non_poll(output acc_t e, output bit ok);
    ok = 0;
    e = '0;
    for (int i = 0; i < 12; i++) begin
      bit got;
      next_acc(e, got);
      if (!got) break;
      if (e.is_wr || e.a != 3'd0) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic send_tx(input logic [7:0] b, output bit ok);
    int n;
    n = 0;
    tx_data = b;
    tx_valid = 1;
    while (!tx_ready && n < 400) begin
      @(negedge clock);
      n++;
    end
    ok = tx_ready;
    @(posedge clock);
    #1 tx_valid = 0;
    @(negedge clock);
  endtask

  task automatic test_reset;
    acc_t e;
    bit ok;
    repeat (3) @(negedge clock);
    reset = 1;
    next_acc(e, ok);
    vectors++;
    if (!ok || e !== mk(1'b1, 3'd0, 8'h04)) begin
      miscompares++;
      $display("FAIL reset_init_write: got %h expected %h", e, mk(1'b1, 3'd0, 8'h04));
    end
    next_acc(e, ok);
    vectors++;
    if (!ok || e !== mk(1'b0, 3'd0, 8'h00) || cs !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid_read: got acc %h cs %b expected acc %h cs 0", e, cs, mk(1'b0, 3'd0, 8'h00));
    end
    reset = 0;
    @(negedge clock);
    vectors++;
    if ({cs, wr, rd_strobe, rx_valid, tx_ready, timeout_err, addr, bus_wdata, rx_data} !==
        {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 8'h00}) begin
      miscompares++;
      $display("FAIL reset_outputs: got cs%b wr%b strb%b rxv%b txr%b to%b a%h wd%h rd%h expected cs1 wr1 strb0 rxv0 txr0 to0 a0 wd00 rd00",
               cs, wr, rd_strobe, rx_valid, tx_ready, timeout_err, addr, bus_wdata, rx_data);
    end
    repeat (3) @(negedge clock);
    acc_q.delete();
    reset = 1;
    next_acc(e, ok);
    vectors++;
    if (!ok || e !== mk(1'b1, 3'd0, 8'h04)) begin
      miscompares++;
      $display("FAIL reset_reinit_write: got %h expected %h", e, mk(1'b1, 3'd0, 8'h04));
    end
  endtask

  task automatic test_tx_write;
    acc_t e;
    bit ok;
    ctl_reg = 8'h00;
    send_tx(8'h55, ok);
    vectors++;
    if (!ok || tx_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL tx_accept: got accepted %b tx_ready %b expected accepted 1 tx_ready 0", ok, tx_ready);
    end
    acc_q.delete();
    next_acc(e, ok);
    vectors++;
    if (!ok || e !== mk(1'b0, 3'd0, 8'h00)) begin
      miscompares++;
      $display("FAIL tx_poll: got %h expected %h", e, mk(1'b0, 3'd0, 8'h00));
    end
    next_acc(e, ok);
    vectors++;
    if (!ok || e !== mk(1'b1, 3'd2, 8'h55)) begin
      miscompares++;
      $display("FAIL tx_write: got %h expected %h", e, mk(1'b1, 3'd2, 8'h55));
    end
    for (int i = 0; i < GAP; i++) begin
      vectors++;
      if (cs !== 1'b1) begin
        miscompares++;
        $display("FAIL tx_gap%0d: got cs %b expected 1", i, cs);
      end
      @(negedge clock);
    end
  endtask

  task automatic test_tx_busy;
    acc_t e;
    bit ok;
    ctl_reg = 8'h02;
    send_tx(8'hC3, ok);
    acc_q.delete();
    for (int i = 0; i < 3; i++) begin
      next_acc(e, ok);
      vectors++;
      if (!ok || e !== mk(1'b0, 3'd0, 8'h00)) begin
        miscompares++;
        $display("FAIL busy_poll%0d: got %h expected %h", i, e, mk(1'b0, 3'd0, 8'h00));
      end
    end
    ctl_reg = 8'h00;
    next_non_poll(e, ok);
    vectors++;
    if (!ok || e !== mk(1'b1, 3'd2, 8'hC3)) begin
      miscompares++;
      $display("FAIL busy_release_write: got %h expected %h", e, mk(1'b1, 3'd2, 8'hC3));
    end
  endtask

  task automatic test_rx;
    acc_t e;
    bit ok;
    int rx_reads;
    rx_ready = 0;
    rx_reg = 8'hA7;
    ctl_reg = 8'h01;
    acc_q.delete();
    next_non_poll(e, ok);
    vectors++;
    if (!ok || e !== mk(1'b0, 3'd1, 8'h00)) begin
      miscompares++;
      $display("FAIL rx_read: got %h expected %h", e, mk(1'b0, 3'd1, 8'h00));
    end
    next_acc(e, ok);
    vectors++;
    if (!ok || e !== mk(1'b1, 3'd0, 8'h04)) begin
      miscompares++;
      $display("FAIL rx_clear: got %h expected %h", e, mk(1'b1, 3'd0, 8'h04));
    end
    vectors++;
    if (rx_valid !== 1'b1 || rx_data !== 8'hA7) begin
      miscompares++;
      $display("FAIL rx_data: got valid %b data %h expected valid 1 data a7", rx_valid, rx_data);
    end
    ctl_reg = 8'h01;
    rx_reg = 8'h3C;
    acc_q.delete();
    repeat (100) @(negedge clock);
    rx_reads = 0;
    foreach (acc_q[i]) if (!acc_q[i].is_wr && acc_q[i].a == 3'd1) rx_reads++;
    vectors++;
    if (rx_reads != 0 || rx_valid !== 1'b1 || rx_data !== 8'hA7) begin
      miscompares++;
      $display("FAIL rx_stall: got reads %0d valid %b data %h expected reads 0 valid 1 data a7",
               rx_reads, rx_valid, rx_data);
    end
    acc_q.delete();
    rx_ready = 1;
    @(negedge clock);
    vectors++;
    if (rx_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL rx_handshake: got valid %b expected 0", rx_valid);
    end
    next_non_poll(e, ok);
    vectors++;
    if (!ok || e !== mk(1'b0, 3'd1, 8'h00)) begin
      miscompares++;
      $display("FAIL rx_retry_read: got %h expected %h", e, mk(1'b0, 3'd1, 8'h00));
    end
    next_acc(e, ok);
    vectors++;
    if (!ok || e !== mk(1'b1, 3'd0, 8'h04) || rx_data !== 8'h3C) begin
      miscompares++;
      $display("FAIL rx_retry_data: got %h data %h expected %h data 3c", e, rx_data, mk(1'b1, 3'd0, 8'h04));
    end
  endtask

  task automatic test_rx_before_tx;
    acc_t e;
    bit ok;
    rx_ready = 1;
    ctl_reg = 8'h02;
    send_tx(8'h96, ok);
    rx_reg = 8'h5A;
    ctl_reg = 8'h01;
    acc_q.delete();
    next_non_poll(e, ok);
    vectors++;
    if (!ok || e !== mk(1'b0, 3'd1, 8'h00)) begin
      miscompares++;
      $display("FAIL prio_rx_first: got %h expected %h", e, mk(1'b0, 3'd1, 8'h00));
    end
    next_acc(e, ok);
    vectors++;
    if (!ok || e !== mk(1'b1, 3'd0, 8'h04) || rx_data !== 8'h5A) begin
      miscompares++;
      $display("FAIL prio_clear: got %h data %h expected %h data 5a", e, rx_data, mk(1'b1, 3'd0, 8'h04));
    end
    next_non_poll(e, ok);
    vectors++;
    if (!ok || e !== mk(1'b1, 3'd2, 8'h96)) begin
      miscompares++;
      $display("FAIL prio_tx_after: got %h expected %h", e, mk(1'b1, 3'd2, 8'h96));
    end
  endtask

  task automatic test_irq;
    acc_t e;
    bit ok;
    int n;
    ctl_reg = 8'h04;
    acc_q.delete();
    next_acc(e, ok);
    repeat (8) @(negedge clock);
    irq = 1;
    @(negedge clock);
    irq = 0;
    n = 0;
    while (acc_q.size() == 0 && n < 400) begin
      @(negedge clock);
      n++;
    end
    next_acc(e, ok);
    vectors++;
    if (!ok || e !== mk(1'b0, 3'd0, 8'h00) || n > 3) begin
      miscompares++;
      $display("FAIL irq_idle: got %h after %0d cycles expected %h within 3", e, n, mk(1'b0, 3'd0, 8'h00));
    end
    irq = 1;
    @(negedge clock);
    irq = 0;
    n = 0;
    while (acc_q.size() == 0 && n < 400) begin
      @(negedge clock);
      n++;
    end
    next_acc(e, ok);
    vectors++;
    if (!ok || e !== mk(1'b0, 3'd0, 8'h00) || n > 10) begin
      miscompares++;
      $display("FAIL irq_latched: got %h after %0d cycles expected %h within 10", e, n, mk(1'b0, 3'd0, 8'h00));
    end
    n = 0;
    while (acc_q.size() == 0 && n < 400) begin
      @(negedge clock);
      n++;
    end
    next_acc(e, ok);
    vectors++;
    if (!ok || n <= 12) begin
      miscompares++;
      $display("FAIL irq_consumed: got next poll after %0d cycles expected more than 12", n);
    end
  endtask

  task automatic test_timeout;
    acc_t e;
    bit ok;
    int k;
    acc_q.delete();
    no_busy = 1;
    next_acc(e, ok);
    k = 1;
    while (timeout_err !== 1'b1 && k < 200) begin
      @(negedge clock);
      k++;
    end
    vectors++;
    if (!ok || timeout_err !== 1'b1 || k != TIMEOUT + 1 || cs !== 1'b1) begin
      miscompares++;
      $display("FAIL timeout: got err %b at cycle %0d cs %b expected err 1 at cycle %0d cs 1",
               timeout_err, k, cs, TIMEOUT + 1);
    end
    no_busy = 0;
    acc_q.delete();
    next_acc(e, ok);
    repeat (5) @(negedge clock);
    vectors++;
    if (!ok || e !== mk(1'b0, 3'd0, 8'h00) || timeout_err !== 1'b1) begin
      miscompares++;
      $display("FAIL timeout_recover: got %h err %b expected %h err 1", e, timeout_err, mk(1'b0, 3'd0, 8'h00));
    end
  endtask

  initial begin
    @(negedge clock);
    test_reset();
    test_tx_write();
    test_tx_busy();
    test_rx();
    test_rx_before_tx();
    test_irq();
    test_timeout();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, expected finish before 500000 ns");
    $fatal(1);
  end

endmodule
